// File: rtl/riscv_fetch_aligner_pkg.sv
// Shared constants and helpers for the fetch aligner.
// It covers the halfword/block geometry and the rule that detects compressed instructions.
package riscv_fetch_aligner_pkg;

  localparam int HW_W         = 16;
  localparam int BLOCK_BYTES  = 8;
  localparam int HW_PER_BLOCK = (BLOCK_BYTES * 8) / HW_W;

  typedef logic [HW_W-1:0]             hw_t;
  typedef hw_t  [HW_PER_BLOCK-1:0]     block_t;

  // An instruction is 16-bit unless its two low opcode bits are both set.
  function automatic logic is_compressed(input hw_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_fetch_aligner_hwqueue.sv
// Circular halfword queue used by the fetch aligner.
// Features: 4-wide masked push of a fetched block, pop of 1 or 2 entries, flush, head/head+1 read ports.
module riscv_falign_hwqueue
  import riscv_fetch_aligner_pkg::*;
#(
  parameter  int DEPTH_HW = 8,
  localparam int PTR_W    = $clog2(DEPTH_HW),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  block_t           push_data,
  input  logic [1:0]       push_skip,
  input  logic             pop,
  input  logic             pop_two,
  output hw_t              hw0,
  output hw_t              hw1,
  output logic [CNT_W-1:0] count
);

  hw_t              queue [DEPTH_HW];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] pop_n;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    push_n = '0;
    pop_n  = '0;
    if (push) push_n = CNT_W'(HW_PER_BLOCK) - CNT_W'(push_skip);
    if (pop)  pop_n  = pop_two ? CNT_W'(2) : CNT_W'(1);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: the storage array is cleared on reset as well, so hw0/hw1 never read X.
      for (int i = 0; i < DEPTH_HW; i++) queue[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // Halfwords skip..3 land in consecutive slots starting at tail.
      if (push) begin
        for (int k = 0; k < HW_PER_BLOCK; k++) begin
          if (k >= int'(push_skip))
            queue[tail + PTR_W'(k) - PTR_W'(push_skip)] <= push_data[k];
        end
      end
      tail  <= tail + push_n[PTR_W-1:0];
      head  <= head + pop_n[PTR_W-1:0];
      count <= count + push_n - pop_n;
    end
  end

  assign hw0 = queue[head];
  assign hw1 = queue[head + PTR_W'(1)];

endmodule

// File: rtl/riscv_fetch_aligner.sv
// Instruction prefetch/alignment buffer that feeds the fetch stage.
// It fetches 8-byte blocks and presents one 32-bit (or zero-extended 16-bit) instruction at pc.
module riscv_fetch_aligner
  import riscv_fetch_aligner_pkg::*;
#(
  parameter int          DEPTH_HW = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_riscv_falign_clk,
  input  logic        i_riscv_falign_rst,
  output logic        o_riscv_falign_reqvalid,
  output logic [63:0] o_riscv_falign_reqaddr,
  input  logic        i_riscv_falign_reqready,
  input  logic        i_riscv_falign_rspvalid,
  input  logic [63:0] i_riscv_falign_rspdata,
  input  logic        i_riscv_falign_redirect,
  input  logic [63:0] i_riscv_falign_redirectpc,
  input  logic        i_riscv_falign_advance,
  output logic [31:0] o_riscv_falign_inst,
  output logic        o_riscv_falign_instvalid,
  output logic        o_riscv_falign_compressed,
  output logic [63:0] o_riscv_falign_pc
);

  localparam int               PTR_W      = $clog2(DEPTH_HW);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] REQ_LIMIT  = CNT_W'(DEPTH_HW - HW_PER_BLOCK);
  localparam logic [63:0]      BLOCK_MASK = ~64'(BLOCK_BYTES - 1);

  logic             clk;
  logic             rst;
  logic [63:0]      faddr;
  logic [63:0]      pc;
  logic [63:0]      target;
  logic [1:0]       skip;
  logic             outstanding;
  logic             discard;
  logic [CNT_W-1:0] count;
  hw_t              hw0;
  hw_t              hw1;
  logic             handshake;
  logic             rsp_accept;
  logic             push;
  logic             pop;
  logic             compressed;
  logic             instvalid;

  assign clk = i_riscv_falign_clk;
  assign rst = i_riscv_falign_rst;

  // Requests reserve a full block of free entries, so a push can never overflow.
  always_comb begin
    target     = {i_riscv_falign_redirectpc[63:1], 1'b0};
    o_riscv_falign_reqvalid = !rst && !outstanding && !discard && (count <= REQ_LIMIT);
    handshake  = o_riscv_falign_reqvalid && i_riscv_falign_reqready;
    rsp_accept = i_riscv_falign_rspvalid && outstanding;
    push       = rsp_accept && !discard && !i_riscv_falign_redirect;
    compressed = (count != '0) && is_compressed(hw0);
    instvalid  = compressed || (count >= CNT_W'(2));
    pop        = i_riscv_falign_advance && instvalid && !i_riscv_falign_redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      faddr       <= RESET_PC & BLOCK_MASK;
      skip        <= RESET_PC[2:1];
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (i_riscv_falign_redirect) begin
      pc    <= target;
      faddr <= target & BLOCK_MASK;
      skip  <= target[2:1];
      // A request still in flight after the redirect returns stale data; mark it for dropping.
      if (rsp_accept) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding || handshake) begin
        outstanding <= 1'b1;
        discard     <= 1'b1;
      end
    end else begin
      if (handshake) begin
        outstanding <= 1'b1;
        faddr       <= faddr + 64'(BLOCK_BYTES);
      end
      if (rsp_accept) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
        if (!discard) skip <= 2'd0;
      end
      if (pop) pc <= pc + (compressed ? 64'd2 : 64'd4);
    end
  end

  riscv_falign_hwqueue #(.DEPTH_HW(DEPTH_HW)) u_hwqueue (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_riscv_falign_redirect),
    .push      (push),
    .push_data (i_riscv_falign_rspdata),
    .push_skip (skip),
    .pop       (pop),
    .pop_two   (!compressed),
    .hw0       (hw0),
    .hw1       (hw1),
    .count     (count)
  );

  assign o_riscv_falign_reqaddr    = faddr;
  assign o_riscv_falign_pc         = pc;
  assign o_riscv_falign_instvalid  = instvalid;
  assign o_riscv_falign_compressed = compressed;
  assign o_riscv_falign_inst       = !instvalid ? 32'h0 :
                                     compressed ? {16'h0, hw0} : {hw1, hw0};

endmodule
